// File: rtl/sdhci_rsp_receiver.sv
// SD host command-response receiver.
// Arms on start_i, waits for the response start bit on CMD (with timeout), shifts in a 48-bit
// or 136-bit response, checks CRC7 / index / end bit, and pulses done_o.
// Optional R1b busy wait on DAT0 is compiled in with the macro SDHCI_RSP_BUSY_EN.
module sdhci_rsp_receiver #(
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic         sd_clk_i,
   input  logic         sd_rst_i,
   input  logic         start_i,
   input  logic         long_rsp_i,
   input  logic         check_index_i,
   input  logic         check_crc_i,
   input  logic [5:0]   expected_index_i,
   input  logic         busy_i,
   input  logic         sd_cmd_i,
   input  logic         sd_dat0_i,
   output logic         done_o,
   output logic [119:0] response_o,
   output logic [5:0]   index_o,
   output logic         timeout_err_o,
   output logic         crc_err_o,
   output logic         end_bit_err_o,
   output logic         index_err_o,
   output logic         busy_o
);

   localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
   // The start_i edge is the first edge of the timeout window, so the timeout fires after
   // TimeoutCycles-1 idle WAIT_START samples and done_o is seen on the TimeoutCycles-th edge.
   localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 32'd2);

`ifdef SDHCI_RSP_BUSY_EN
   typedef enum logic [2:0] {StIdle, StWaitStart, StReceive, StBusy, StDone} state_e;
`else
   typedef enum logic [2:0] {StIdle, StWaitStart, StReceive, StDone} state_e;
`endif

   state_e         state_q, state_d;
   logic           long_q, long_d;
   logic           chk_idx_q, chk_idx_d;
   logic           chk_crc_q, chk_crc_d;
   logic [5:0]     exp_idx_q, exp_idx_d;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   // Remaining bits to sample after the start bit; the bit position sampled is rem_q-1.
   logic [7:0]     rem_q, rem_d;
   logic [6:0]     crc_q, crc_d;
   // Holds response bits 127..1 with bit 1 at index 0.
   logic [126:0]   sr_q, sr_d;
   logic [119:0]   rsp_q, rsp_d;
   logic [5:0]     idx_q, idx_d;
   logic           to_err_q, to_err_d;
   logic           crc_err_q, crc_err_d;
   logic           eb_err_q, eb_err_d;
   logic           idx_err_q, idx_err_d;
   logic [7:0]     pos;
   logic           crc_take;
   state_e         after_rx;

`ifdef SDHCI_RSP_BUSY_EN
   logic busy_q, busy_d;
`else
   logic unused_busy_in;
   assign unused_busy_in = busy_i ^ sd_dat0_i;
`endif

   // Serial CRC7, polynomial x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign pos = rem_q - 8'd1;
   // R1: CRC over bits 47..8; R2: the check bits 134..128 are excluded.
   assign crc_take = (pos >= 8'd8) && (!long_q || (pos <= 8'd127));

`ifdef SDHCI_RSP_BUSY_EN
   assign after_rx = busy_q ? StBusy : StDone;
   assign busy_o   = (state_q == StBusy);
`else
   assign after_rx = StDone;
   assign busy_o   = 1'b0;
`endif

   assign done_o        = (state_q == StDone);
   assign response_o    = rsp_q;
   assign index_o       = idx_q;
   assign timeout_err_o = to_err_q;
   assign crc_err_o     = crc_err_q;
   assign end_bit_err_o = eb_err_q;
   assign index_err_o   = idx_err_q;

   // Next-state logic for the receive FSM and its datapath.
   always_comb begin
      state_d   = state_q;
      long_d    = long_q;
      chk_idx_d = chk_idx_q;
      chk_crc_d = chk_crc_q;
      exp_idx_d = exp_idx_q;
      to_cnt_d  = to_cnt_q;
      rem_d     = rem_q;
      crc_d     = crc_q;
      sr_d      = sr_q;
      rsp_d     = rsp_q;
      idx_d     = idx_q;
      to_err_d  = to_err_q;
      crc_err_d = crc_err_q;
      eb_err_d  = eb_err_q;
      idx_err_d = idx_err_q;
`ifdef SDHCI_RSP_BUSY_EN
      busy_d    = busy_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               long_d    = long_rsp_i;
               chk_idx_d = check_index_i;
               chk_crc_d = check_crc_i;
               exp_idx_d = expected_index_i;
`ifdef SDHCI_RSP_BUSY_EN
               busy_d    = busy_i;
`endif
               rsp_d     = '0;
               idx_d     = '0;
               to_err_d  = 1'b0;
               crc_err_d = 1'b0;
               eb_err_d  = 1'b0;
               idx_err_d = 1'b0;
               to_cnt_d  = '0;
               state_d   = StWaitStart;
            end
         end
         StWaitStart: begin
            if (!sd_cmd_i) begin
               rem_d   = long_q ? 8'd135 : 8'd47;
               crc_d   = crc7_step(7'd0, 1'b0);
               sr_d    = '0;
               state_d = StReceive;
            end else if (to_cnt_q == ToLast) begin
               to_err_d = 1'b1;
               state_d  = StDone;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         StReceive: begin
            rem_d = pos;
            if (pos == 8'd0) begin
               // End bit: latch payload regardless of any error found.
               if (long_q) begin
                  rsp_d     = sr_q[126:7];
                  idx_d     = '0;
                  idx_err_d = 1'b0;
               end else begin
                  rsp_d     = {88'd0, sr_q[38:7]};
                  idx_d     = sr_q[44:39];
                  idx_err_d = chk_idx_q && (sr_q[44:39] != exp_idx_q);
               end
               crc_err_d = chk_crc_q && (crc_q != sr_q[6:0]);
               eb_err_d  = !sd_cmd_i;
               state_d   = after_rx;
            end else begin
               sr_d = {sr_q[125:0], sd_cmd_i};
               if (crc_take) begin
                  crc_d = crc7_step(crc_q, sd_cmd_i);
               end
            end
         end
`ifdef SDHCI_RSP_BUSY_EN
         StBusy: begin
            if (sd_dat0_i) begin
               state_d = StDone;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge sd_clk_i) begin
      if (sd_rst_i) begin
         state_q   <= StIdle;
         long_q    <= 1'b0;
         chk_idx_q <= 1'b0;
         chk_crc_q <= 1'b0;
         exp_idx_q <= '0;
         to_cnt_q  <= '0;
         rem_q     <= '0;
         crc_q     <= '0;
         sr_q      <= '0;
         rsp_q     <= '0;
         idx_q     <= '0;
         to_err_q  <= 1'b0;
         crc_err_q <= 1'b0;
         eb_err_q  <= 1'b0;
         idx_err_q <= 1'b0;
`ifdef SDHCI_RSP_BUSY_EN
         busy_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         long_q    <= long_d;
         chk_idx_q <= chk_idx_d;
         chk_crc_q <= chk_crc_d;
         exp_idx_q <= exp_idx_d;
         to_cnt_q  <= to_cnt_d;
         rem_q     <= rem_d;
         crc_q     <= crc_d;
         sr_q      <= sr_d;
         rsp_q     <= rsp_d;
         idx_q     <= idx_d;
         to_err_q  <= to_err_d;
         crc_err_q <= crc_err_d;
         eb_err_q  <= eb_err_d;
         idx_err_q <= idx_err_d;
`ifdef SDHCI_RSP_BUSY_EN
         busy_q    <= busy_d;
`endif
      end
   end

endmodule

// File: tb/tb_sdhci_rsp_receiver.sv
// Scoreboard bench for sdhci_rsp_receiver: stimulus pushes expected completions, a negedge
// monitor pops and compares whenever done_o is seen.
module tb_sdhci_rsp_receiver;

`ifdef SDHCI_RSP_BUSY_EN
   localparam bit BusyEn = 1'b1;
`else
   localparam bit BusyEn = 1'b0;
`endif

   logic         sd_clk_i = 1'b0;
   logic         sd_rst_i;
   logic         start_i;
   logic         long_rsp_i;
   logic         check_index_i;
   logic         check_crc_i;
   logic [5:0]   expected_index_i;
   logic         busy_i;
   logic         sd_cmd_i;
   logic         sd_dat0_i;
   logic         done_o;
   logic [119:0] response_o;
   logic [5:0]   index_o;
   logic         timeout_err_o;
   logic         crc_err_o;
   logic         end_bit_err_o;
   logic         index_err_o;
   logic         busy_o;

   sdhci_rsp_receiver #(.TimeoutCycles(64)) dut (
      .sd_clk_i         (sd_clk_i),
      .sd_rst_i         (sd_rst_i),
      .start_i          (start_i),
      .long_rsp_i       (long_rsp_i),
      .check_index_i    (check_index_i),
      .check_crc_i      (check_crc_i),
      .expected_index_i (expected_index_i),
      .busy_i           (busy_i),
      .sd_cmd_i         (sd_cmd_i),
      .sd_dat0_i        (sd_dat0_i),
      .done_o           (done_o),
      .response_o       (response_o),
      .index_o          (index_o),
      .timeout_err_o    (timeout_err_o),
      .crc_err_o        (crc_err_o),
      .end_bit_err_o    (end_bit_err_o),
      .index_err_o      (index_err_o),
      .busy_o           (busy_o)
   );

   always #5 sd_clk_i = ~sd_clk_i;

   typedef struct {
      int           lat;
      logic [119:0] rsp;
      logic [5:0]   idx;
      logic         to;
      logic         crc;
      logic         eb;
      logic         ie;
      int           busy_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   busy_seen = 0;

   localparam logic [119:0] Cid = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;

   always @(posedge sd_clk_i) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = hi; i >= lo; i--) begin
         fb = c[6] ^ v[i];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   function automatic logic [135:0] r1_frame(input logic [5:0] idx, input logic [31:0] st);
      logic [135:0] f;
      f        = '0;
      f[47:8]  = {2'b00, idx, st};
      f[7:1]   = crc7(f, 47, 8);
      f[0]     = 1'b1;
      return f;
   endfunction

   function automatic logic [135:0] r2_frame(input logic [119:0] cid);
      logic [135:0] f;
      f          = '0;
      f[135:128] = 8'b0011_1111;
      f[127:8]   = cid;
      f[7:1]     = crc7(f, 127, 8);
      f[0]       = 1'b1;
      return f;
   endfunction

   function automatic void expect_rsp(input int lat, input logic [119:0] rsp, input logic [5:0] idx,
                                      input logic to, input logic crc, input logic eb,
                                      input logic ie, input int bc);
      exp_t e;
      e.lat = lat; e.rsp = rsp; e.idx = idx; e.to = to; e.crc = crc; e.eb = eb; e.ie = ie;
      e.busy_cyc = bc;
      sb_q.push_back(e);
   endfunction

   // Monitor: latency is the edge (counted from the start_i edge) on which done_o is sampled.
   always @(negedge sd_clk_i) begin
      exp_t e;
      if (busy_o) busy_seen++;
      if (done_o) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
         end else begin
            e = sb_q.pop_front();
            chk("latency", 120'(cyc - start_cyc + 1), 120'(e.lat));
            chk("response", response_o, e.rsp);
            chk("index", 120'(index_o), 120'(e.idx));
            chk("timeout_err", 120'(timeout_err_o), 120'(e.to));
            chk("crc_err", 120'(crc_err_o), 120'(e.crc));
            chk("end_bit_err", 120'(end_bit_err_o), 120'(e.eb));
            chk("index_err", 120'(index_err_o), 120'(e.ie));
            chk("busy_cycles", 120'(busy_seen), 120'(e.busy_cyc));
         end
         busy_seen = 0;
      end
   end

   task automatic drive_bit(input logic b);
      sd_cmd_i = b;
      @(posedge sd_clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1);
   endtask

   task automatic pulse_start(input logic lng, input logic ci, input logic cc, input logic [5:0] ei,
                              input logic bz);
      long_rsp_i       = lng;
      check_index_i    = ci;
      check_crc_i      = cc;
      expected_index_i = ei;
      busy_i           = bz;
      start_i          = 1'b1;
      @(posedge sd_clk_i);
      #1;
      start_i   = 1'b0;
      start_cyc = cyc;
   endtask

   // Start bit lands on edge 'delay' after the start_i edge; ends #1 after the end-bit edge.
   task automatic send_frame(input logic [135:0] f, input int nbits, input int delay);
      for (int i = 0; i < delay - 1; i++) drive_bit(1'b1);
      for (int i = nbits - 1; i >= 0; i--) drive_bit(f[i]);
      sd_cmd_i = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_done"}, 120'(done_o), 120'd0);
      chk({tag, "_busy"}, 120'(busy_o), 120'd0);
      chk({tag, "_response"}, response_o, 120'd0);
      chk({tag, "_index"}, 120'(index_o), 120'd0);
      chk({tag, "_errors"}, 120'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}), 120'd0);
   endtask

   initial begin
      logic [135:0] f;
      sd_rst_i = 1'b1; start_i = 1'b0; long_rsp_i = 1'b0; check_index_i = 1'b0;
      check_crc_i = 1'b0; expected_index_i = '0; busy_i = 1'b0; sd_cmd_i = 1'b1;
      sd_dat0_i = 1'b1;
      repeat (3) @(posedge sd_clk_i);
      #1;
      check_all_zero("reset");
      sd_rst_i = 1'b0;
      idle(3);

      // Valid R1, index 17, status 0x900.
      pulse_start(1'b0, 1'b1, 1'b1, 6'd17, 1'b0);
      expect_rsp(51, 120'h900, 6'd17, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(r1_frame(6'd17, 32'h0000_0900), 48, 3);
      idle(5);

      // CRC LSB flipped.
      f = r1_frame(6'd17, 32'h0000_0900);
      f[1] = ~f[1];
      pulse_start(1'b0, 1'b1, 1'b1, 6'd17, 1'b0);
      expect_rsp(51, 120'h900, 6'd17, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      send_frame(f, 48, 3);
      idle(5);

      // Index mismatch; a start_i coincident with done_o must be ignored.
      pulse_start(1'b0, 1'b1, 1'b1, 6'd18, 1'b0);
      expect_rsp(51, 120'h900, 6'd17, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send_frame(r1_frame(6'd17, 32'h0000_0900), 48, 3);
      start_i = 1'b1;
      @(posedge sd_clk_i);
      #1;
      start_i = 1'b0;
      idle(70);
      chk("hold_response", response_o, 120'h900);
      chk("hold_index_err", 120'(index_err_o), 120'd1);

      // Reset clears held outputs.
      sd_rst_i = 1'b1;
      @(posedge sd_clk_i);
      #1;
      sd_rst_i = 1'b0;
      check_all_zero("reset_hold");

      // Timeout with CMD held high.
      pulse_start(1'b0, 1'b1, 1'b1, 6'd17, 1'b0);
      expect_rsp(64, 120'h0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      idle(70);

      // End bit driven low.
      f = r1_frame(6'd17, 32'h0000_0900);
      f[0] = 1'b0;
      pulse_start(1'b0, 1'b1, 1'b1, 6'd17, 1'b0);
      expect_rsp(51, 120'h900, 6'd17, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      send_frame(f, 48, 3);
      idle(5);

      // R2 with CID; index check requested but ignored for long responses.
      pulse_start(1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
      expect_rsp(138, Cid, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(r2_frame(Cid), 136, 2);
      idle(5);

      // R1b: DAT0 low for 10 edges after the end bit.
      sd_dat0_i = 1'b0;
      pulse_start(1'b0, 1'b1, 1'b1, 6'd17, 1'b1);
      expect_rsp(BusyEn ? 62 : 51, 120'h900, 6'd17, 1'b0, 1'b0, 1'b0, 1'b0, BusyEn ? 11 : 0);
      send_frame(r1_frame(6'd17, 32'h0000_0900), 48, 3);
      repeat (10) @(posedge sd_clk_i);
      #1;
      sd_dat0_i = 1'b1;
      idle(5);

      // Reset mid-RECEIVE coincident with start_i, then a fresh valid R1.
      f = r1_frame(6'd42, 32'hDEAD_BEEF);
      pulse_start(1'b0, 1'b1, 1'b1, 6'd42, 1'b0);
      idle(2);
      for (int i = 47; i >= 28; i--) drive_bit(f[i]);
      sd_rst_i = 1'b1;
      start_i  = 1'b1;
      sd_cmd_i = 1'b1;
      @(posedge sd_clk_i);
      #1;
      sd_rst_i = 1'b0;
      start_i  = 1'b0;
      check_all_zero("reset_mid_rx");
      idle(70);
      pulse_start(1'b0, 1'b1, 1'b1, 6'd42, 1'b0);
      expect_rsp(53, 120'hDEAD_BEEF, 6'd42, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send_frame(f, 48, 5);
      idle(5);

      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge sd_clk_i);
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL pending_completions: got %0d outstanding expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
